pool_avg_seq: RTL and testbench
===============================

Name: pool_avg_seq

Overview:
- Channel sequencer for the average-pooling datapath.
- On start, for each of cfg_channels channels it:
  - reads the channel's feature map from the activation buffer;
  - streams the pixels into the pooling unit with the matching size code;
  - waits for the pooled result;
  - writes the result to the output buffer at the channel index.
- Sits between the activation SRAM, the pooling unit and the pooled-vector buffer that feeds the FC stage.

Parameters:
- DATA_W, 9, pixel and result width.
- ADDR_W, 16, activation buffer address width.
- CH_W, 10, channel counter width (max 1023 channels).
- TIMEOUT, 64, maximum cycles to wait for the pool result after the last pixel.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous reset, active-high (asserted = 1).
- start  in  1  one-cycle pulse; ignored unless in IDLE.
- cfg_size  in  2  0 = 28x28 (784 px), 1 = 14x14 (196), 2 = 7x7 (49), 3 = illegal.
- cfg_channels  in  CH_W  number of channels; 0 = no work.
- cfg_base  in  ADDR_W  activation buffer base address.
- rd_en  out  1  activation buffer read strobe.
- rd_addr  out  ADDR_W  read address.
- rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en.
- pool_data_in  out  DATA_W  pixel to the pooling unit.
- pool_valid  out  1  pixel valid.
- pool_size  out  10  pixel count (784/196/49), held stable for the whole channel.
- pool_data  in  DATA_W  pooled average.
- pool_valid_out  in  1  pooled average valid (single-cycle pulse).
- wr_en  out  1  output buffer write.
- wr_addr  out  CH_W  channel index.
- wr_data  out  DATA_W  pooled value.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a job.
- err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; counters 0.
  - Reset mid-job aborts immediately; no write is issued after reset deasserts.
- Config latch: cfg_* are sampled on the start cycle and held internally; later changes have no effect.
- States:
  - IDLE -> LOAD on start with cfg_channels != 0 and cfg_size != 3.
  - start with cfg_channels == 0: done pulses next cycle, busy stays 0, err stays 0.
  - start with cfg_size == 3: err = 1, done pulses next cycle, nothing else happens.
  - LOAD:
    - rd_en = 1 every cycle.
    - rd_addr = cfg_base + ch*N + px, with px = 0..N-1 (N = pixel count).
    - After px = N-1 is issued -> WAIT.
    - Address arithmetic wraps modulo 2^ADDR_W.
  - Pixel path: pool_valid and pool_data_in are rd_en and rd_data delayed by exactly 1 cycle, so pool_valid is high for exactly N consecutive cycles per channel, with no bubbles.
  - WAIT:
    - On pool_valid_out: latch pool_data -> WRITE.
    - A pool_valid_out arriving in the same cycle as the last pool_valid is accepted.
    - A pool_valid_out seen in LOAD is ignored and sets err.
  - WRITE:
    - wr_en = 1 for one cycle; wr_addr = ch; wr_data = latched value.
    - If ch == cfg_channels-1 -> DONE; else increment ch and return to LOAD on the next cycle.
  - DONE: done = 1 for one cycle, busy drops in the same cycle -> IDLE.
- Channel timing:
  - Issue to write is N + 1 + pool latency + 1 cycles.
  - Consecutive channels are never overlapped.
- start while busy is ignored, with no side effect.

Optional Feature:
- Macro: POOL_AVG_SEQ_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter runs.
  - If TIMEOUT cycles elapse in WAIT without pool_valid_out: err = 1, wr_en is issued with wr_data = 0 for that channel, and sequencing continues.
- Undefined:
  - No counter; WAIT holds indefinitely until pool_valid_out or reset.
  - err is set only by the illegal-size and early-result conditions.

Test Plan:
- 7x7, cfg_channels = 2, cfg_base = 0x100, pool model returns sum/49 three cycles after the last pixel:
  - rd_addr runs 0x100..0x161 contiguously;
  - pool_valid is high for 49 cycles per channel;
  - wr_en fires at addresses 0 and 1 with the correct averages;
  - a single done pulse follows; err = 0.
- 28x28, one channel, data = i mod 512:
  - exactly 784 pool_valid cycles;
  - pool_size = 784 throughout;
  - one write at address 0.
- Edge starts:
  - cfg_channels = 0 -> done the cycle after start, with no rd_en or wr_en;
  - cfg_size = 3 -> err = 1 and done, with no reads.
- Mid-LOAD disturbances, 14x14:
  - reset asserted at px = 100 -> all outputs 0 asynchronously; IDLE after release; a new start runs cleanly;
  - a second start during LOAD is ignored.
- Timeout, with POOL_AVG_SEQ_TIMEOUT_EN defined and the pool model silent on channel 0:
  - after 64 WAIT cycles: err = 1 and wr_en at address 0 with data 0;
  - channel 1 then completes normally.
  - With the macro undefined, the sequencer stays in WAIT with busy = 1 for 1000 cycles.

Source files
------------

// File: rtl/pool_avg_seq_if.sv
`default_nettype none
//==============================================================================
// Module   : pool_avg_seq_if
// Brief    : Control, activation-read, pooling-unit and output-write signals
//            of the pool_avg_seq channel sequencer.
// Revision : 1.0 - initial release
//==============================================================================
interface pool_avg_seq_if #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 16,
    parameter int CH_W   = 10
);
    logic              start;
    logic [1:0]        cfg_size;
    logic [CH_W-1:0]   cfg_channels;
    logic [ADDR_W-1:0] cfg_base;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    logic [DATA_W-1:0] pool_data_in;
    logic              pool_valid;
    logic [9:0]        pool_size;
    logic [DATA_W-1:0] pool_data;
    logic              pool_valid_out;

    logic              wr_en;
    logic [CH_W-1:0]   wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, cfg_size, cfg_channels, cfg_base,
        input  rd_data, pool_data, pool_valid_out,
        output rd_en, rd_addr, pool_data_in, pool_valid, pool_size,
        output wr_en, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        output start, cfg_size, cfg_channels, cfg_base,
        output rd_data, pool_data, pool_valid_out,
        input  rd_en, rd_addr, pool_data_in, pool_valid, pool_size,
        input  wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/pool_avg_seq.sv
`default_nettype none
//==============================================================================
// Module   : pool_avg_seq
// Brief    : Channel sequencer for the average-pooling datapath. Streams each
//            channel's feature map into the pooling unit and stores the result.
//            Define POOL_AVG_SEQ_TIMEOUT_EN to bound the wait for a result.
// Revision : 1.0 - initial release
//==============================================================================
module pool_avg_seq #(
    parameter int DATA_W  = 9,
    parameter int ADDR_W  = 16,
    parameter int CH_W    = 10,
    parameter int TIMEOUT = 64
) (
    input  wire            clk,
    input  wire            reset_n,
    pool_avg_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [9:0] c_N_28 = 10'd784;
    localparam logic [9:0] c_N_14 = 10'd196;
    localparam logic [9:0] c_N_7  = 10'd49;

    state_t            r_state;
    state_t            w_next_state;
    logic [9:0]        r_n;
    logic [9:0]        r_px;
    logic [CH_W-1:0]   r_channels;
    logic [CH_W-1:0]   r_ch;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_result;
    logic              r_err;
    logic              r_pool_valid;
    logic [9:0]        w_cfg_n;
    logic              w_cfg_ok;
    logic              w_last_px;
    logic              w_last_ch;
    logic              w_timeout;

    generate
        if (TIMEOUT < 1) begin : g_timeout_range
            $error("pool_avg_seq: TIMEOUT must be at least 1");
        end
    endgenerate

    always_comb begin
        w_cfg_n = '0;
        case (bus.cfg_size)
            2'd0:    w_cfg_n = c_N_28;
            2'd1:    w_cfg_n = c_N_14;
            2'd2:    w_cfg_n = c_N_7;
            default: w_cfg_n = '0;
        endcase
    end

    assign w_cfg_ok  = (bus.cfg_size != 2'd3) && (bus.cfg_channels != '0);
    assign w_last_px = (r_px == r_n - 10'd1);
    assign w_last_ch = (r_ch == r_channels - CH_W'(1));

`ifdef POOL_AVG_SEQ_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT + 1);

    logic [c_TO_W-1:0] r_wait_cnt;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Fires on the TIMEOUT-th WAIT cycle; a real result in that cycle still wins.
    assign w_timeout = (r_state == S_WAIT) && !bus.pool_valid_out &&
                       (r_wait_cnt == c_TO_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = w_cfg_ok ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                if (w_last_px) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.pool_valid_out || w_timeout) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: w_next_state = w_last_ch ? S_DONE : S_LOAD;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_n          <= '0;
            r_px         <= '0;
            r_channels   <= '0;
            r_ch         <= '0;
            r_addr       <= '0;
            r_result     <= '0;
            r_err        <= 1'b0;
            r_pool_valid <= 1'b0;
        end else begin
            r_pool_valid <= (r_state == S_LOAD);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_err <= (bus.cfg_size == 2'd3);
                        if (w_cfg_ok) begin
                            r_n        <= w_cfg_n;
                            r_channels <= bus.cfg_channels;
                            r_addr     <= bus.cfg_base;
                            r_ch       <= '0;
                            r_px       <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    // Channels sit back to back, so one running address covers base + ch*N + px.
                    r_addr <= r_addr + ADDR_W'(1);
                    r_px   <= w_last_px ? '0 : r_px + 10'd1;
                    if (bus.pool_valid_out) begin
                        r_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.pool_valid_out) begin
                        r_result <= bus.pool_data;
                    end else if (w_timeout) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!w_last_ch) begin
                        r_ch <= r_ch + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_en        = (r_state == S_LOAD);
    assign bus.rd_addr      = bus.rd_en ? r_addr : '0;
    assign bus.pool_valid   = r_pool_valid;
    assign bus.pool_data_in = r_pool_valid ? bus.rd_data : '0;
    assign bus.pool_size    = r_n;
    assign bus.wr_en        = (r_state == S_WRITE);
    assign bus.wr_addr      = bus.wr_en ? r_ch : '0;
    assign bus.wr_data      = bus.wr_en ? r_result : '0;
    assign bus.busy         = (r_state == S_LOAD) || (r_state == S_WAIT) || (r_state == S_WRITE);
    assign bus.done         = (r_state == S_DONE);
    assign bus.err          = r_err;
endmodule
`default_nettype wire

// File: tb/tb_pool_avg_seq.sv
`default_nettype none
//==============================================================================
// Module   : tb_pool_avg_seq
// Brief    : Scoreboard bench for pool_avg_seq with activation-SRAM and
//            pooling-unit models. POOL_AVG_SEQ_TIMEOUT_EN selects the WAIT test.
// Revision : 1.0 - initial release
//==============================================================================
module tb_pool_avg_seq;
    localparam int DATA_W = 9;
    localparam int ADDR_W = 16;
    localparam int CH_W   = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pool_avg_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CH_W(CH_W)) bus ();

    pool_avg_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CH_W   (CH_W),
        .TIMEOUT(64)
    ) dut (
        .clk    (clk),
        .reset_n(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_exp_t;

    int                n_checks    = 0;
    int                n_errors    = 0;
    int                exp_rd_q[$];
    wr_exp_t           exp_wr_q[$];
    int                exp_err_q[$];
    int                exp_n       = 0;
    int                rd_seen     = 0;
    int                done_seen   = 0;
    int                jobs_issued = 0;
    int                run_len     = 0;
    longint            cyc         = 0;
    wr_exp_t           mon_e;
    logic [DATA_W-1:0] mem [0:65535];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int px_count(input int size);
        case (size)
            0:       return 784;
            1:       return 196;
            2:       return 49;
            default: return 0;
        endcase
    endfunction

    // Activation SRAM: data appears the cycle after the read strobe.
    logic              sram_en   = 1'b0;
    logic [ADDR_W-1:0] sram_addr = '0;
    always @(negedge clk) begin
        sram_en   = bus.rd_en;
        sram_addr = bus.rd_addr;
    end
    always @(posedge clk) begin
        cyc++;
        #1;
        bus.rd_data = sram_en ? mem[sram_addr] : DATA_W'($urandom);
    end

    // Pooling unit: averages pool_size pixels, answers pm_lat cycles after the last.
    int     pm_cnt = 0;
    int     pm_sum = 0;
    int     pm_lat = 0;
    bit     pm_silent_first = 1'b0;
    bit     pm_inject = 1'b0;
    longint pm_due[$];
    int     pm_val[$];
    always @(negedge clk) begin
        bus.pool_valid_out = 1'b0;
        bus.pool_data      = DATA_W'($urandom);
        if (!rst && bus.pool_valid) begin
            pm_sum += int'(bus.pool_data_in);
            pm_cnt++;
            if (pm_cnt == int'(bus.pool_size)) begin
                if (pm_silent_first) begin
                    pm_silent_first = 1'b0;
                end else begin
                    pm_due.push_back(cyc + longint'(pm_lat));
                    pm_val.push_back(pm_sum / pm_cnt);
                end
                pm_cnt = 0;
                pm_sum = 0;
            end
        end
        if (pm_due.size() != 0 && pm_due[0] == cyc) begin
            void'(pm_due.pop_front());
            bus.pool_valid_out = 1'b1;
            bus.pool_data      = DATA_W'(pm_val.pop_front());
        end else if (pm_inject) begin
            pm_inject          = 1'b0;
            bus.pool_valid_out = 1'b1;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_en) begin
                rd_seen++;
                if (exp_rd_q.size() == 0) check("rd_unexpected", int'(bus.rd_en), 0);
                else                      check("rd_addr", int'(bus.rd_addr), exp_rd_q.pop_front());
            end
            if (bus.pool_valid) begin
                run_len++;
                check("pool_size", int'(bus.pool_size), exp_n);
            end else if (run_len != 0) begin
                check("pool_run_len", run_len, exp_n);
                run_len = 0;
            end
            if (bus.wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", int'(bus.wr_en), 0);
                end else begin
                    mon_e = exp_wr_q.pop_front();
                    check("wr_addr", int'(bus.wr_addr), mon_e.addr);
                    check("wr_data", int'(bus.wr_data), mon_e.data);
                end
            end
            if (bus.done) begin
                done_seen++;
                check("busy_at_done", int'(bus.busy), 0);
                if (exp_err_q.size() == 0) check("done_unexpected", int'(bus.done), 0);
                else                       check("err_at_done", int'(bus.err), exp_err_q.pop_front());
            end
        end
    end

    task automatic start_job(input int size, input int chans, input int base, input int lat,
                             input bit exp_err, input bit zero_ch0);
        int      n;
        int      sum;
        int      a;
        wr_exp_t e;
        n       = px_count(size);
        rd_seen = 0;
        if (size == 3) begin
            exp_err_q.push_back(1);
        end else if (chans == 0) begin
            exp_err_q.push_back(0);
        end else begin
            exp_n = n;
            for (int ch = 0; ch < chans; ch++) begin
                sum = 0;
                for (int p = 0; p < n; p++) begin
                    a = (base + ch * n + p) % 65536;
                    exp_rd_q.push_back(a);
                    sum += int'(mem[ADDR_W'(a)]);
                end
                e.addr = ch;
                e.data = (zero_ch0 && ch == 0) ? 0 : sum / n;
                exp_wr_q.push_back(e);
            end
            exp_err_q.push_back(int'(exp_err));
        end
        pm_lat = lat;
        jobs_issued++;
        @(posedge clk); #1;
        bus.start        = 1'b1;
        bus.cfg_size     = 2'(size);
        bus.cfg_channels = CH_W'(chans);
        bus.cfg_base     = ADDR_W'(base);
        @(posedge clk); #1;
        bus.start        = 1'b0;
        bus.cfg_size     = 2'($urandom);
        bus.cfg_channels = CH_W'($urandom);
        bus.cfg_base     = ADDR_W'($urandom);
        if (size == 3 || chans == 0) begin
            check("done_next_cycle", int'(bus.done), 1);
            check("busy_idle_job", int'(bus.busy), 0);
            check("err_on_done", int'(bus.err), int'(size == 3));
        end else begin
            check("busy_after_start", int'(bus.busy), 1);
            check("err_cleared", int'(bus.err), 0);
        end
    endtask

    task automatic pulse_start(input int size, input int chans, input int base);
        @(posedge clk); #1;
        bus.start        = 1'b1;
        bus.cfg_size     = 2'(size);
        bus.cfg_channels = CH_W'(chans);
        bus.cfg_base     = ADDR_W'(base);
        @(posedge clk); #1;
        bus.start        = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int k = 0;
        while (done_seen < jobs_issued && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
        check(name, int'(done_seen >= jobs_issued), 1);
        check({name, "_rd_left"}, exp_rd_q.size(), 0);
        check({name, "_wr_left"}, exp_wr_q.size(), 0);
    endtask

    task automatic wait_reads(input string name, input int target);
        int k = 0;
        while (rd_seen < target && k < 5000) begin
            @(negedge clk); #1;
            k++;
        end
        check(name, int'(rd_seen >= target), 1);
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        #1;
        check("rst_rd_en", int'(bus.rd_en), 0);
        check("rst_rd_addr", int'(bus.rd_addr), 0);
        check("rst_pool_valid", int'(bus.pool_valid), 0);
        check("rst_pool_size", int'(bus.pool_size), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_wr_done_err", int'({bus.wr_en, bus.done, bus.err}), 0);
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_err_q.delete();
        pm_due.delete();
        pm_val.delete();
        pm_cnt          = 0;
        pm_sum          = 0;
        pm_silent_first = 1'b0;
        pm_inject       = 1'b0;
        run_len         = 0;
        done_seen       = 0;
        jobs_issued     = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_busy", int'(bus.busy), 0);
        check("post_rst_rd_en", int'(bus.rd_en), 0);
    endtask

    initial begin
        int busy_low;
        bus.start        = 1'b0;
        bus.cfg_size     = '0;
        bus.cfg_channels = '0;
        bus.cfg_base     = '0;
        for (int i = 0; i < 65536; i++) mem[i] = DATA_W'($urandom);

        repeat (3) @(negedge clk);
        check("reset_rd_en", int'(bus.rd_en), 0);
        check("reset_pool_valid", int'(bus.pool_valid), 0);
        check("reset_pool_size", int'(bus.pool_size), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_wr_done_err", int'({bus.wr_en, bus.done, bus.err}), 0);
        rst = 1'b0;

        start_job(2, 2, 'h100, 3, 1'b0, 1'b0);
        wait_done("t1_7x7", 500);
        check("t1_err", int'(bus.err), 0);

        for (int i = 0; i < 784; i++) mem[ADDR_W'('h2000 + i)] = DATA_W'(i % 512);
        start_job(0, 1, 'h2000, int'($urandom_range(0, 5)), 1'b0, 1'b0);
        wait_done("t2_28x28", 2000);

        start_job(2, 0, 'h300, 0, 1'b0, 1'b0);
        wait_done("t3_zero_ch", 20);
        start_job(3, 2, 'h300, 0, 1'b1, 1'b0);
        wait_done("t3_bad_size", 20);
        check("t3_err_sticky", int'(bus.err), 1);

        for (int j = 0; j < 4; j++) begin
            start_job(int'($urandom_range(1, 2)), int'($urandom_range(1, 3)),
                      (j == 0) ? 'hFFE0 : int'($urandom_range(0, 65535)),
                      int'($urandom_range(0, 5)), 1'b0, 1'b0);
            wait_done("t4_random", 3000);
        end

        start_job(1, 2, 'h4000, 0, 1'b0, 1'b0);
        wait_reads("t5_reads", 20);
        pulse_start(2, 5, 'h0);
        wait_done("t5_restart_ignored", 2000);

        start_job(2, 1, 'h5000, 1, 1'b1, 1'b0);
        wait_reads("t6_reads", 10);
        pm_inject = 1'b1;
        wait_done("t6_early_result", 500);

        start_job(1, 2, 'h6000, 2, 1'b0, 1'b0);
        wait_reads("t7_reads", 100);
        #2;
        assert_reset();
        start_job(2, 1, 'h7000, 4, 1'b0, 1'b0);
        wait_done("t7_after_reset", 500);

`ifdef POOL_AVG_SEQ_TIMEOUT_EN
        pm_silent_first = 1'b1;
        start_job(2, 2, 'h8000, 3, 1'b1, 1'b1);
        wait_done("t8_timeout", 1000);
`else
        pm_silent_first = 1'b1;
        start_job(2, 2, 'h8000, 3, 1'b0, 1'b0);
        busy_low = 0;
        repeat (1000) begin
            @(negedge clk); #1;
            if (!bus.busy) busy_low++;
        end
        check("t8_wait_holds_busy", busy_low, 0);
        check("t8_no_write", exp_wr_q.size(), 2);
        #2;
        assert_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
